// File: rtl/fwd_hazard_unit_if.sv
// Issue/operand/forwarding bundle between the ID stage and the forwarding/hazard unit.
// master = pipeline control side, slave = fwd_hazard_unit.
interface fwd_hazard_unit_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned NSRC   = 2,
   parameter int unsigned DEPTH  = 3
);
   localparam int unsigned SELW = $clog2(DEPTH + 1);

   logic                     issue_valid;
   logic                     issue_wen;
   logic                     issue_is_load;
   logic [REG_AW-1:0]        issue_rd;
   logic [NSRC-1:0]          src_valid;
   logic [NSRC*REG_AW-1:0]   src_addr;
   logic                     flush;
   logic                     stall;
   logic [NSRC*SELW-1:0]     ex_fwd_sel;
   logic [15:0]              stall_count;

   modport master (
      output issue_valid, issue_wen, issue_is_load, issue_rd,
      output src_valid, src_addr, flush,
      input  stall, ex_fwd_sel, stall_count
   );

   modport slave (
      input  issue_valid, issue_wen, issue_is_load, issue_rd,
      input  src_valid, src_addr, flush,
      output stall, ex_fwd_sel, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit: tracks in-flight destinations in a
// DEPTH-entry shift register and matches ID-stage sources against it.
module fwd_hazard_unit #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NSRC     = 2,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LOAD_LAT = 1
) (
   input logic               clk,
   input logic               rst,
   fwd_hazard_unit_if.slave  bus
);
   localparam int unsigned SELW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              v;
      logic              ld;
      logic [REG_AW-1:0] rd;
   } entry_t;

   entry_t                e_q [1:DEPTH];
   entry_t                e_d [1:DEPTH];
   logic [NSRC*SELW-1:0]  sel_q, sel_d;
   logic [15:0]           cnt_q, cnt_d;

   logic [SELW-1:0]       m_c [NSRC];
   logic [NSRC-1:0]       hz_c;
   logic                  stall_c;
   logic                  accept_c;

   // Per-source match: scan oldest to youngest so the youngest match is kept.
   always_comb begin
      hz_c = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         m_c[i] = '0;
         for (int k = int'(DEPTH); k >= 1; k--) begin
            if (bus.src_valid[i] && e_q[k].v &&
                (e_q[k].rd == bus.src_addr[i*REG_AW +: REG_AW])) begin
               m_c[i]  = SELW'(k);
               hz_c[i] = e_q[k].ld && (k <= int'(LOAD_LAT));
            end
         end
      end
   end

   assign stall_c  = !rst && bus.issue_valid && !bus.flush && (|hz_c);
   assign accept_c = bus.issue_valid && !stall_c && !bus.flush;

   // Next-state: shift tracker, register selects, saturating stall counter.
   always_comb begin
      for (int k = 1; k <= int'(DEPTH); k++) e_d[k] = '0;
      sel_d = '0;
      cnt_d = cnt_q;

      if (accept_c) begin
         e_d[1].v  = bus.issue_wen && (bus.issue_rd != '0);
         e_d[1].ld = bus.issue_is_load;
         e_d[1].rd = bus.issue_rd;
      end

      // A flush kills the instruction currently in EX as it moves on.
      e_d[2]   = e_q[1];
      e_d[2].v = e_q[1].v && !bus.flush;
      for (int k = 2; k < int'(DEPTH); k++) e_d[k+1] = e_q[k];

      if (accept_c) begin
         for (int i = 0; i < int'(NSRC); i++) sel_d[i*SELW +: SELW] = m_c[i];
      end

      if (stall_c && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k <= int'(DEPTH); k++) e_q[k] <= '0;
         sel_q <= '0;
         cnt_q <= '0;
      end else begin
         for (int k = 1; k <= int'(DEPTH); k++) e_q[k] <= e_d[k];
         sel_q <= sel_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.stall       = stall_c;
   assign bus.ex_fwd_sel  = sel_q;
   assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with default parameters (DEPTH=3, LOAD_LAT=1).
module tb_fwd_hazard_unit;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   fwd_hazard_unit_if #(.REG_AW(5), .NSRC(2), .DEPTH(3)) bus ();

   fwd_hazard_unit #(.REG_AW(5), .NSRC(2), .DEPTH(3), .LOAD_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int v, input int wen, input int ld, input int rd,
                         input int sv, input int s0, input int s1, input int fl);
      bus.issue_valid   = 1'(v);
      bus.issue_wen     = 1'(wen);
      bus.issue_is_load = 1'(ld);
      bus.issue_rd      = 5'(rd);
      bus.src_valid     = 2'(sv);
      bus.src_addr      = {5'(s1), 5'(s0)};
      bus.flush         = 1'(fl);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ALU op: writes rd, reads s0 and s1
   task automatic op(input int rd, input int s0, input int s1);
      set_in(1, 1, 0, rd, 3, s0, s1, 0);
      tick();
   endtask

   task automatic idle(input int n);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < n; j++) tick();
   endtask

   function automatic logic [31:0] sel2(input int f1, input int f0);
      logic [3:0] s;
      s = {2'(f1), 2'(f0)};
      return 32'(s);
   endfunction

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", 32'(bus.stall), 32'd0);
      chk("reset_sel",   32'(bus.ex_fwd_sel), 32'd0);
      chk("reset_count", 32'(bus.stall_count), 32'd0);
      rst = 1'b0;
      idle(1);

      // back-to-back ALU
      op(3, 1, 2);
      set_in(1, 1, 0, 5, 3, 3, 3, 0);
      chk("b2b_stall", 32'(bus.stall), 32'd0);
      tick();
      chk("b2b_sel1", 32'(bus.ex_fwd_sel), sel2(1, 1));
      idle(3);
      chk("drain_sel", 32'(bus.ex_fwd_sel), 32'd0);

      op(3, 1, 2); op(7, 1, 2); op(5, 3, 3);
      chk("gap1_sel2", 32'(bus.ex_fwd_sel), sel2(2, 2));
      idle(3);

      op(3, 1, 2); op(7, 1, 2); op(7, 1, 2); op(5, 3, 3);
      chk("gap2_sel3", 32'(bus.ex_fwd_sel), sel2(3, 3));
      idle(3);

      op(3, 1, 2); op(7, 1, 2); op(7, 1, 2); op(7, 1, 2); op(5, 3, 3);
      chk("gap3_sel0", 32'(bus.ex_fwd_sel), 32'd0);
      idle(3);

      // youngest wins
      op(3, 1, 2); op(3, 1, 2); op(5, 3, 3);
      chk("youngest", 32'(bus.ex_fwd_sel), sel2(1, 1));
      idle(3);

      // r0 never matches; src_valid gates
      op(0, 1, 2); op(5, 0, 0);
      chk("r0_nomatch", 32'(bus.ex_fwd_sel), 32'd0);
      idle(3);
      op(3, 1, 2);
      set_in(1, 1, 0, 5, 1, 3, 3, 0);
      tick();
      chk("srcvalid_gate", 32'(bus.ex_fwd_sel), sel2(0, 1));
      idle(3);

      // load-use: one stall cycle, bubble, then MEM/WB forward
      set_in(1, 1, 1, 4, 1, 1, 0, 0); tick();
      set_in(1, 1, 0, 6, 3, 4, 1, 0);
      chk("lu_stall1", 32'(bus.stall), 32'd1);
      chk("lu_count0", 32'(bus.stall_count), 32'd0);
      tick();
      chk("lu_bubble", 32'(bus.ex_fwd_sel), 32'd0);
      chk("lu_count1", 32'(bus.stall_count), 32'd1);
      chk("lu_stall_clr", 32'(bus.stall), 32'd0);
      tick();
      chk("lu_sel", 32'(bus.ex_fwd_sel), sel2(0, 2));
      idle(3);

      // flush during the stall cycle
      set_in(1, 1, 1, 4, 1, 1, 0, 0); tick();
      set_in(1, 1, 0, 6, 3, 4, 1, 1);
      chk("fl_stall", 32'(bus.stall), 32'd0);
      tick();
      chk("fl_sel", 32'(bus.ex_fwd_sel), 32'd0);
      chk("fl_count", 32'(bus.stall_count), 32'd1);
      set_in(1, 1, 0, 8, 3, 6, 4, 0);
      chk("fl_nodep_stall", 32'(bus.stall), 32'd0);
      tick();
      chk("fl_nodep_sel", 32'(bus.ex_fwd_sel), 32'd0);
      idle(3);

      // flush leaves older entries intact
      op(3, 1, 2); op(7, 1, 2);
      set_in(1, 1, 0, 8, 3, 3, 3, 1);
      chk("fl_old_stall", 32'(bus.stall), 32'd0);
      tick();
      chk("fl_old_sel0", 32'(bus.ex_fwd_sel), 32'd0);
      op(5, 3, 3);
      chk("fl_old_sel3", 32'(bus.ex_fwd_sel), sel2(3, 3));
      idle(3);

      // reset mid-run with live entries and a pending stall
      op(3, 1, 2);
      set_in(1, 1, 1, 4, 1, 3, 0, 0); tick();
      chk("rm_pre_sel", 32'(bus.ex_fwd_sel), sel2(0, 1));
      set_in(1, 1, 0, 6, 3, 4, 4, 0);
      chk("rm_pre_stall", 32'(bus.stall), 32'd1);
      chk("rm_pre_count", 32'(bus.stall_count), 32'd1);
      rst = 1'b1;
      #1;
      chk("rm_stall", 32'(bus.stall), 32'd0);
      chk("rm_sel",   32'(bus.ex_fwd_sel), 32'd0);
      chk("rm_count", 32'(bus.stall_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("rm_post_stall", 32'(bus.stall), 32'd0);
      tick();
      chk("rm_post_sel", 32'(bus.ex_fwd_sel), 32'd0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It tracks the destination registers of in-flight instructions in an internal shift register of depth DEPTH. It compares each ID-stage source operand against that shift register and registers per-operand forwarding selects into the EX stage. It also raises a stall when a source depends on a load whose data is not yet forwardable, and counts stall cycles.

## Interface
Parameters:
- REG_AW, 5, register address width.
- NSRC, 2, number of source operands checked per instruction.
- DEPTH, 3, number of tracked stages past ID; entry 1 = instruction in EX. DEPTH ≥ 2.
- LOAD_LAT, 1, a load is not forwardable while at entry k ≤ LOAD_LAT. Range 0..DEPTH-1.
- SELW, $clog2(DEPTH+1), width of one forward select (derived).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- issue_valid, in, 1, ID holds a valid instruction attempting to move to EX.
- issue_wen, in, 1, that instruction writes a register.
- issue_is_load, in, 1, that instruction is a load.
- issue_rd, in, REG_AW, its destination register.
- src_valid, in, NSRC, bit i: source i is actually read (e.g. Rt only for R-type).
- src_addr, in, NSRC*REG_AW, source i at bits [i*REG_AW +: REG_AW].
- flush, in, 1, kill the instructions in ID and EX (branch taken).
- stall, out, 1, combinational; hold PC/IF/ID this cycle.
- ex_fwd_sel, out, NSRC*SELW, registered. Per source: 0 = register file; k = forward from the pipeline register k stages after EX (1 = EX/MEM, 2 = MEM/WB, …).
- stall_count, out, 16, saturating count of stall cycles.

## Operation
- Entry e[k], k = 1..DEPTH, holds {v, ld, rd}. v = 1 only if the instruction writes and rd ≠ 0.
- Match for source i: src_valid[i] & e[k].v & (e[k].rd == src_addr[i]). Address 0 never matches.
- Youngest match wins: m_i = the smallest k that matches, or none.
- Hazard for source i: m_i exists, e[m_i].ld = 1, and m_i ≤ LOAD_LAT.
- stall = issue_valid & !flush & (OR of the hazards of all sources).
- Shift on every clock edge, including during stall: e[k+1] ← e[k] for k = 1..DEPTH-1; e[DEPTH] is discarded.
  - The write is complete and the register file writes through.
- e[1] ← {issue_wen & (issue_rd ≠ 0), issue_is_load, issue_rd} when issue_valid & !stall & !flush.
  - Otherwise e[1] ← invalid (bubble).
- ex_fwd_sel field i ← m_i when issue_valid & !stall & !flush; 0 when there is no match. Otherwise all fields ← 0.
- Flush: the incoming instruction is dropped and the current e[1] shifts to e[2] as invalid (EX instruction killed). Older entries are unaffected.
- stall_count increments on every cycle with stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous): all e[k].v = 0, ex_fwd_sel = 0, stall_count = 0. stall = 0 while rst is high.
- Sources presented in cycle t produce ex_fwd_sel valid in cycle t+1, the cycle the consumer is in EX. Latency is 1.
- A load at entry k stalls a dependent consumer for LOAD_LAT - k + 1 cycles.
  - The load advances one entry per stall cycle, so the stall self-clears.
  - With LOAD_LAT = 1, a load immediately ahead of its consumer gives 1 stall cycle, then ex_fwd_sel = 2.
- Stall and flush in the same cycle: flush wins, stall = 0, and a bubble is inserted.
- Multiple sources with different hazards: stall persists until the slowest hazard resolves.
- LOAD_LAT = 0: the unit never stalls.

## Test plan
Defaults: REG_AW = 5, NSRC = 2, DEPTH = 3, LOAD_LAT = 1.
- Reset mid-run: assert rst with valid entries held → stall = 0, ex_fwd_sel = 0 and stall_count = 0 immediately. A dependent issue after release gives select 0.
- Back-to-back ALU ops: add r3 then sub r5,r3,r3 → next cycle both fields of ex_fwd_sel = 1. With one unrelated instruction in between, both = 2. With two in between, both = 3. With three in between, both = 0.
- Youngest wins: add r3, add r3, use r3 → field = 1, not 2.
- Register 0 and src_valid: write r0, then use r0 → field 0. Match on Rt with src_valid[1] = 0 → field 1 = 0.
- Load-use: lw r4, then add r6,r4,r1 → stall = 1 for exactly 1 cycle, the bubble gives ex_fwd_sel = 0, then field 0 = 2. stall_count goes from 0 to 1.
- Flush during stall: lw r4, dependent issue, flush asserted in the stall cycle → stall = 0 that cycle, ex_fwd_sel = 0, the dependent is not recorded in e[1], and stall_count is unchanged.
